// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC, FSM encoding, buffer payload.
package if_fetch_stage_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000;

  // ST_FETCH = 1'b0, ST_FULL = 1'b1
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FULL  = 1'b1
  } fetch_state_e;

  // Instruction held for decode
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              adel;
  } fetch_buf_t;

  // Word fetch address must be 4-byte aligned
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bundle of redirect, instruction-memory and decode handshake signals around the fetch stage.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_instr;
  logic              if_adel;
  logic              id_ready;

  // Fetch stage side
  modport master (
    input  redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_instr, if_adel
  );

  // Environment side: next-PC logic, instruction memory, decode
  modport slave (
    output redirect_valid, redirect_pc, imem_ack, imem_rdata, id_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, if_adel
  );

endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, req/ack memory fetch, one-entry decode buffer, redirect handling.
module if_fetch_stage #(
  parameter logic [if_fetch_stage_pkg::ADDR_W-1:0] RESET_PC = if_fetch_stage_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  if_fetch_stage_if.master  bus
);
  import if_fetch_stage_pkg::*;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pending_pc_q;
  logic              drop_q;
  logic              armed_q;
  logic              valid_q;
  fetch_buf_t        buf_q;
  logic              req_c;
  logic              ack_c;

  // Request only from registered state so redirect/id_ready never reach imem_req combinationally;
  // armed_q keeps the request low while reset is held.
  assign req_c = (state_q == ST_FETCH) && armed_q && !is_misaligned(pc_q);
  assign ack_c = req_c && bus.imem_ack;

  assign bus.imem_req  = req_c;
  assign bus.imem_addr = {pc_q[ADDR_W-1:2], 2'b00};
  assign bus.if_valid  = valid_q;
  assign bus.if_pc     = buf_q.pc;
  assign bus.if_instr  = buf_q.instr;
  assign bus.if_adel   = buf_q.adel;

  // FSM, PC, pending redirect and decode buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      pending_pc_q <= RESET_PC;
      drop_q       <= 1'b0;
      armed_q      <= 1'b0;
      valid_q      <= 1'b0;
      buf_q        <= '{pc: RESET_PC, instr: '0, adel: 1'b0};
    end else begin
      armed_q <= 1'b1;
      unique case (state_q)
        ST_FETCH: begin
          if (bus.redirect_valid) begin
            if (req_c && !bus.imem_ack) begin
              // Outstanding request cannot be withdrawn; discard its response later
              drop_q       <= 1'b1;
              pending_pc_q <= bus.redirect_pc;
            end else begin
              // Response (if any) this cycle is discarded; newest target wins
              pc_q   <= bus.redirect_pc;
              drop_q <= 1'b0;
            end
          end else if (ack_c) begin
            if (drop_q) begin
              pc_q   <= pending_pc_q;
              drop_q <= 1'b0;
            end else begin
              buf_q   <= '{pc: pc_q, instr: bus.imem_rdata, adel: 1'b0};
              valid_q <= 1'b1;
              pc_q    <= ADDR_W'(pc_q + ADDR_W'(4));
              state_q <= ST_FULL;
            end
          end else if (is_misaligned(pc_q)) begin
            // Misaligned PC: hand decode an address-error bubble without touching memory
            buf_q   <= '{pc: pc_q, instr: '0, adel: 1'b1};
            valid_q <= 1'b1;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (bus.redirect_valid) begin
            valid_q <= 1'b0;
            pc_q    <= bus.redirect_pc;
            state_q <= ST_FETCH;
          end else if (valid_q && bus.id_ready) begin
            valid_q <= 1'b0;
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_FETCH;
      endcase
    end
  end

endmodule
